// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared state encoding and width limits for the bit-serial adder
package serial_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit combinational full adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder, one full_adder cell, start/busy/done handshake
module serial_adder
  import serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("serial_adder: WIDTH out of range");
  end

  state_t           state, next_state;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum, fa_c_out;
  logic             last_bit, accept;

  full_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .c_in (carry),
    .sum  (fa_sum),
    .c_out(fa_c_out)
  );

  // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  if (WIDTH == 1) begin : g_one
    assign res_next = fa_sum;
  end else begin : g_wide
    assign res_next = {fa_sum, res_sr[WIDTH-1:1]};
  end

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign accept   = start && (state == S_IDLE || state == S_DONE);
  assign busy     = (state == S_RUN);
  assign done     = (state == S_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_RUN;
      S_RUN:   if (last_bit) next_state = S_DONE;
      S_DONE:  next_state = start ? S_RUN : S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      c_out  <= 1'b0;
    end else if (accept) begin
      a_sr   <= a;
      b_sr   <= b;
      res_sr <= '0;
      carry  <= c_in;
      cnt    <= '0;
    end else if (state == S_RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_next;
      carry  <= fa_c_out;
      cnt    <= cnt + CW'(1);
      // Outputs only move on the final bit so partial sums are never visible.
      if (last_bit) begin
        sum   <= res_next;
        c_out <= fa_c_out;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder at WIDTH 8, 1 and 13
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  start_v = '0;
  logic [2:0]  cin_v = '0;
  logic [31:0] a_v [3];
  logic [31:0] b_v [3];
  wire  [2:0]  busy_v, done_v, cout_v;
  wire  [7:0]  s8;
  wire  [0:0]  s1;
  wire  [12:0] s13;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          d;
    logic [32:0] v;
  } sb_t;
  sb_t sb[$];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .reset(reset), .start(start_v[0]), .a(a_v[0][7:0]), .b(b_v[0][7:0]),
    .c_in(cin_v[0]), .busy(busy_v[0]), .done(done_v[0]), .sum(s8), .c_out(cout_v[0])
  );
  serial_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .a(a_v[1][0:0]), .b(b_v[1][0:0]),
    .c_in(cin_v[1]), .busy(busy_v[1]), .done(done_v[1]), .sum(s1), .c_out(cout_v[1])
  );
  serial_adder #(.WIDTH(13)) u_w13 (
    .clk(clk), .reset(reset), .start(start_v[2]), .a(a_v[2][12:0]), .b(b_v[2][12:0]),
    .c_in(cin_v[2]), .busy(busy_v[2]), .done(done_v[2]), .sum(s13), .c_out(cout_v[2])
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int width_of(input int d);
    case (d)
      0:       return 8;
      1:       return 1;
      default: return 13;
    endcase
  endfunction

  function automatic logic [31:0] sum_of(input int d);
    case (d)
      0:       return {24'b0, s8};
      1:       return {31'b0, s1};
      default: return {19'b0, s13};
    endcase
  endfunction

  function automatic logic [63:0] result_of(input int d);
    return ({63'b0, cout_v[d]} << width_of(d)) | {32'b0, sum_of(d)};
  endfunction

  // Every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    sb_t e;
    for (int i = 0; i < 3; i++) begin
      if (done_v[i]) begin
        check_eq("done_excl_busy", {63'b0, busy_v[i]}, 64'd0);
        check_eq("sb_nonempty", {63'b0, sb.size() > 0}, 64'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check_eq("sb_dut", 64'(i), 64'(e.d));
          check_eq("sb_result", result_of(i), {31'b0, e.v});
        end
      end
    end
  end

  task automatic launch(input int d, input logic [31:0] a, input logic [31:0] b, input logic cin);
    logic [31:0] m;
    sb_t e;
    m = (32'd1 << width_of(d)) - 32'd1;
    a_v[d] = a & m;
    b_v[d] = b & m;
    cin_v[d] = cin;
    start_v[d] = 1'b1;
    e.d = d;
    e.v = {1'b0, a & m} + {1'b0, b & m} + {32'b0, cin};
    sb.push_back(e);
    @(posedge clk);
    #1 start_v[d] = 1'b0;
  endtask

  // Called just after the accepting edge; returns at the negedge inside the done cycle.
  task automatic wait_done(input int d, input bit timing);
    logic [63:0] prev;
    bit seen;
    prev = result_of(d);
    seen = 1'b0;
    for (int c = 0; c < width_of(d) + 6 && !seen; c++) begin
      @(negedge clk);
      if (done_v[d]) begin
        seen = 1'b1;
        if (timing) check_eq("latency", 64'(c), 64'(width_of(d)));
      end else if (timing) begin
        check_eq("busy_in_run", {63'b0, busy_v[d]}, 64'd1);
        check_eq("result_hold", result_of(d), prev);
      end
    end
    check_eq("done_seen", {63'b0, seen}, 64'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      check_eq("idle_busy", {61'b0, busy_v}, 64'd0);
      check_eq("idle_done", {61'b0, done_v}, 64'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      a_v[i] = '0;
      b_v[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", {61'b0, busy_v}, 64'd0);
    check_eq("rst_done", {61'b0, done_v}, 64'd0);
    check_eq("rst_cout", {61'b0, cout_v}, 64'd0);
    check_eq("rst_sum", {42'b0, s13, s8, s1}, 64'd0);
    reset = 1'b0;
    idle(1);

    launch(0, 32'h5A, 32'h3C, 1'b0);
    wait_done(0, 1'b1);
    check_eq("t1_sum", {56'b0, s8}, 64'h96);
    idle(2);

    launch(0, 32'hFF, 32'h01, 1'b0);
    wait_done(0, 1'b1);
    check_eq("t2_result", result_of(0), 64'h100);
    idle(2);

    launch(0, 32'hFF, 32'hFF, 1'b1);
    wait_done(0, 1'b1);
    launch(0, 32'h01, 32'h01, 1'b0);
    wait_done(0, 1'b1);
    check_eq("t3_b2b", result_of(0), 64'h002);
    idle(2);

    launch(0, 32'h10, 32'h20, 1'b0);
    fork
      wait_done(0, 1'b1);
      begin
        @(posedge clk);
        #1;
        a_v[0] = 32'hAA; b_v[0] = 32'h55; start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0; a_v[0] = 32'h0F; b_v[0] = 32'hF0; cin_v[0] = 1'b1;
      end
    join
    check_eq("t4_ignore", result_of(0), 64'h030);
    idle(4);

    launch(0, 32'h12, 32'h34, 1'b0);
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("t5_busy", {63'b0, busy_v[0]}, 64'd0);
    check_eq("t5_done", {63'b0, done_v[0]}, 64'd0);
    check_eq("t5_result", result_of(0), 64'd0);
    sb.delete(sb.size() - 1);
    @(posedge clk);
    #1 reset = 1'b0;
    idle(3);
    launch(0, 32'h03, 32'h04, 1'b0);
    wait_done(0, 1'b1);
    check_eq("t5_after", {56'b0, s8}, 64'h07);
    idle(2);

    launch(1, 32'h1, 32'h1, 1'b1);
    wait_done(1, 1'b1);
    check_eq("t6_w1", result_of(1), 64'h3);
    idle(2);

    for (int i = 0; i < 20; i++) begin
      launch(0, $urandom, $urandom, 1'($urandom_range(1, 0)));
      wait_done(0, 1'(i % 2));
      if ($urandom_range(1, 0) == 1) idle(1);
    end
    idle(2);
    for (int i = 0; i < 20; i++) begin
      launch(2, $urandom, $urandom, 1'($urandom_range(1, 0)));
      wait_done(2, 1'(i % 2));
      if ($urandom_range(1, 0) == 1) idle(1);
    end
    idle(3);
    check_eq("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
